i2c_slave_intf: RTL and testbench

// - Storage and status block behind the I2C slave bus-functional model.
// - Holds the 7-bit slave address the slave answers to.
// - RX FIFO: the slave pushes each data byte received during a master write; the testbench pops them.
// - TX FIFO: the testbench pushes bytes; the slave pops one per byte during a master read.

---
 rtl/i2c_slave_pkg.sv | 22 ++
 rtl/i2c_byte_fifo.sv | 99 +++++++++
 rtl/i2c_slave_intf.sv | 102 ++++++++++
 tb/tb_i2c_slave_intf.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave storage block.
package i2c_slave_pkg;

    localparam int unsigned ADDR_W = 7;
    // Count field is wide enough for any practical FIFO depth.
    localparam int unsigned CNT_W  = 32;

    typedef logic [7:0] byte_t;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             udf;
    } fifo_status_t;

    function automatic int unsigned ptr_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// Byte FIFO with registered read data, sticky overflow/underflow flags and synchronous flush.
module i2c_byte_fifo
    import i2c_slave_pkg::*;
#(
    parameter int unsigned Depth = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [7:0]   wdata_i,
    input  logic         rd_en_i,
    input  logic         flush_i,
    output logic [7:0]   rdata_o,
    output logic         rvalid_o,
    output fifo_status_t status_o
);

    localparam int unsigned W  = $clog2(Depth);
    localparam int unsigned PW = ptr_width(Depth);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    byte_t         rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    byte_t         mem_q [Depth];

    logic empty, full, push, pop;

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[W-1:0] == rptr_q[W-1:0]) && (wptr_q[W] != rptr_q[W]);
        pop   = rd_en_i && !empty && !flush_i;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push  = wr_en_i && (!full || pop) && !flush_i;

        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (pop) begin
                rptr_d   = rptr_q + PW'(1);
                rdata_d  = mem_q[rptr_q[W-1:0]];
                rvalid_d = 1'b1;
            end else if (rd_en_i) begin
                udf_d = 1'b1;
            end
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end else if (wr_en_i) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[W-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        status_o.count = CNT_W'(wptr_q - rptr_q);
        status_o.empty = empty;
        status_o.full  = full;
        status_o.ovf   = ovf_q;
        status_o.udf   = udf_q;
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/i2c_slave_intf.sv
// Storage and status behind the I2C slave model: slave address register plus RX and TX byte FIFOs.
module i2c_slave_intf
    import i2c_slave_pkg::*;
#(
    parameter int unsigned        G_SLAVE_I2C_FIFO_WIDTH = 256,
    parameter logic [ADDR_W-1:0]  G_SLAVE_ADDR_RST       = 7'h00,
    localparam int unsigned       W                      = $clog2(G_SLAVE_I2C_FIFO_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_wr_i,
    input  logic [ADDR_W-1:0] addr_wdata_i,
    output logic [ADDR_W-1:0] slave_addr_o,
    input  logic              rx_wr_en_i,
    input  logic [7:0]        rx_wdata_i,
    input  logic              rx_rd_en_i,
    output logic [7:0]        rx_rdata_o,
    output logic              rx_rvalid_o,
    input  logic              rx_flush_i,
    output logic [W:0]        rx_count_o,
    output logic              rx_empty_o,
    output logic              rx_full_o,
    output logic              rx_ovf_o,
    output logic              rx_udf_o,
    input  logic              tx_wr_en_i,
    input  logic [7:0]        tx_wdata_i,
    input  logic              tx_rd_en_i,
    output logic [7:0]        tx_rdata_o,
    output logic              tx_rvalid_o,
    input  logic              tx_flush_i,
    output logic [W:0]        tx_count_o,
    output logic              tx_empty_o,
    output logic              tx_full_o,
    output logic              tx_ovf_o,
    output logic              tx_udf_o
);

    logic [ADDR_W-1:0] slave_addr_q, slave_addr_d;
    fifo_status_t      rx_st, tx_st;
    logic              unused_cnt_bits;

    always_comb begin
        slave_addr_d = slave_addr_q;
        if (addr_wr_i) begin
            slave_addr_d = addr_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slave_addr_q <= G_SLAVE_ADDR_RST;
        end else begin
            slave_addr_q <= slave_addr_d;
        end
    end

    assign slave_addr_o = slave_addr_q;

    i2c_byte_fifo #(
        .Depth (G_SLAVE_I2C_FIFO_WIDTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (rx_wr_en_i),
        .wdata_i  (rx_wdata_i),
        .rd_en_i  (rx_rd_en_i),
        .flush_i  (rx_flush_i),
        .rdata_o  (rx_rdata_o),
        .rvalid_o (rx_rvalid_o),
        .status_o (rx_st)
    );

    i2c_byte_fifo #(
        .Depth (G_SLAVE_I2C_FIFO_WIDTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (tx_wr_en_i),
        .wdata_i  (tx_wdata_i),
        .rd_en_i  (tx_rd_en_i),
        .flush_i  (tx_flush_i),
        .rdata_o  (tx_rdata_o),
        .rvalid_o (tx_rvalid_o),
        .status_o (tx_st)
    );

    assign rx_count_o = rx_st.count[W:0];
    assign rx_empty_o = rx_st.empty;
    assign rx_full_o  = rx_st.full;
    assign rx_ovf_o   = rx_st.ovf;
    assign rx_udf_o   = rx_st.udf;

    assign tx_count_o = tx_st.count[W:0];
    assign tx_empty_o = tx_st.empty;
    assign tx_full_o  = tx_st.full;
    assign tx_ovf_o   = tx_st.ovf;
    assign tx_udf_o   = tx_st.udf;

    // Upper count bits are always zero for the configured depth.
    assign unused_cnt_bits = ^{rx_st.count[CNT_W-1:W+1], tx_st.count[CNT_W-1:W+1]};

endmodule

// File: tb/tb_i2c_slave_intf.sv
// Bench for i2c_slave_intf: directed scenarios plus random traffic against a queue-based model.
module tb_i2c_slave_intf;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned W     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       addr_wr_i;
    logic [6:0] addr_wdata_i;
    logic [6:0] slave_addr_o;
    logic       rx_wr_en_i, rx_rd_en_i, rx_flush_i;
    logic [7:0] rx_wdata_i, rx_rdata_o;
    logic       rx_rvalid_o, rx_empty_o, rx_full_o, rx_ovf_o, rx_udf_o;
    logic [W:0] rx_count_o;
    logic       tx_wr_en_i, tx_rd_en_i, tx_flush_i;
    logic [7:0] tx_wdata_i, tx_rdata_o;
    logic       tx_rvalid_o, tx_empty_o, tx_full_o, tx_ovf_o, tx_udf_o;
    logic [W:0] tx_count_o;

    always #5 clk = ~clk;

    i2c_slave_intf #(
        .G_SLAVE_I2C_FIFO_WIDTH (DEPTH),
        .G_SLAVE_ADDR_RST       (7'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_wr_i    (addr_wr_i),
        .addr_wdata_i (addr_wdata_i),
        .slave_addr_o (slave_addr_o),
        .rx_wr_en_i   (rx_wr_en_i),
        .rx_wdata_i   (rx_wdata_i),
        .rx_rd_en_i   (rx_rd_en_i),
        .rx_rdata_o   (rx_rdata_o),
        .rx_rvalid_o  (rx_rvalid_o),
        .rx_flush_i   (rx_flush_i),
        .rx_count_o   (rx_count_o),
        .rx_empty_o   (rx_empty_o),
        .rx_full_o    (rx_full_o),
        .rx_ovf_o     (rx_ovf_o),
        .rx_udf_o     (rx_udf_o),
        .tx_wr_en_i   (tx_wr_en_i),
        .tx_wdata_i   (tx_wdata_i),
        .tx_rd_en_i   (tx_rd_en_i),
        .tx_rdata_o   (tx_rdata_o),
        .tx_rvalid_o  (tx_rvalid_o),
        .tx_flush_i   (tx_flush_i),
        .tx_count_o   (tx_count_o),
        .tx_empty_o   (tx_empty_o),
        .tx_full_o    (tx_full_o),
        .tx_ovf_o     (tx_ovf_o),
        .tx_udf_o     (tx_udf_o)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: byte queues plus the visible registered outputs.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [6:0] m_addr;
    logic [7:0] m_rdata  [2];
    logic       m_rvalid [2];
    logic       m_ovf    [2];
    logic       m_udf    [2];

    logic [7:0] rx_vals [3] = '{8'hA5, 8'h3C, 8'hFF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned qsize(input int f);
        return (f == 0) ? rxq.size() : txq.size();
    endfunction

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_addr = 7'h00;
        for (int f = 0; f < 2; f++) begin
            m_rdata[f]  = 8'h00;
            m_rvalid[f] = 1'b0;
            m_ovf[f]    = 1'b0;
            m_udf[f]    = 1'b0;
        end
    endtask

    task automatic fifo_step(input int f, input logic wr, input logic [7:0] wd,
                             input logic rd, input logic fl);
        int unsigned sz;
        logic        popped;
        sz          = qsize(f);
        popped      = 1'b0;
        m_rvalid[f] = 1'b0;
        if (fl) begin
            if (f == 0) rxq.delete(); else txq.delete();
            m_ovf[f] = 1'b0;
            m_udf[f] = 1'b0;
        end else begin
            if (rd) begin
                if (sz > 0) begin
                    if (f == 0) m_rdata[f] = rxq.pop_front();
                    else        m_rdata[f] = txq.pop_front();
                    m_rvalid[f] = 1'b1;
                    popped      = 1'b1;
                end else begin
                    m_udf[f] = 1'b1;
                end
            end
            if (wr) begin
                if (sz < DEPTH || popped) begin
                    if (f == 0) rxq.push_back(wd); else txq.push_back(wd);
                end else begin
                    m_ovf[f] = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp_fifo(input string p, input int f, input logic [7:0] rdata,
                            input logic rvalid, input logic [W:0] cnt, input logic empty,
                            input logic full, input logic ovf, input logic udf);
        int unsigned sz;
        sz = qsize(f);
        chk({p, "_rdata"},  32'(rdata),  32'(m_rdata[f]));
        chk({p, "_rvalid"}, 32'(rvalid), 32'(m_rvalid[f]));
        chk({p, "_count"},  32'(cnt),    sz);
        chk({p, "_empty"},  32'(empty),  32'(sz == 0));
        chk({p, "_full"},   32'(full),   32'(sz == DEPTH));
        chk({p, "_ovf"},    32'(ovf),    32'(m_ovf[f]));
        chk({p, "_udf"},    32'(udf),    32'(m_udf[f]));
    endtask

    task automatic compare_all();
        chk("slave_addr", 32'(slave_addr_o), 32'(m_addr));
        cmp_fifo("rx", 0, rx_rdata_o, rx_rvalid_o, rx_count_o, rx_empty_o, rx_full_o,
                 rx_ovf_o, rx_udf_o);
        cmp_fifo("tx", 1, tx_rdata_o, tx_rvalid_o, tx_count_o, tx_empty_o, tx_full_o,
                 tx_ovf_o, tx_udf_o);
    endtask

    // Inputs change on the falling edge; model follows the rising edge; compare on the next fall.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (addr_wr_i) m_addr = addr_wdata_i;
            fifo_step(0, rx_wr_en_i, rx_wdata_i, rx_rd_en_i, rx_flush_i);
            fifo_step(1, tx_wr_en_i, tx_wdata_i, tx_rd_en_i, tx_flush_i);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        addr_wr_i  = 1'b0;
        rx_wr_en_i = 1'b0;
        rx_rd_en_i = 1'b0;
        rx_flush_i = 1'b0;
        tx_wr_en_i = 1'b0;
        tx_rd_en_i = 1'b0;
        tx_flush_i = 1'b0;
    endtask

    task automatic async_reset();
        idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned wr_pct;
        idle();
        addr_wdata_i = 7'h00;
        rx_wdata_i   = 8'h00;
        tx_wdata_i   = 8'h00;
        rst_n        = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_addr",     32'(slave_addr_o), 32'h00);
        chk("rst_rx_empty", 32'(rx_empty_o),   32'h1);
        chk("rst_tx_empty", 32'(tx_empty_o),   32'h1);
        chk("rst_rx_count", 32'(rx_count_o),   32'h0);
        chk("rst_tx_count", 32'(tx_count_o),   32'h0);
        chk("rst_flags",    32'({rx_ovf_o, rx_udf_o, tx_ovf_o, tx_udf_o}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Address load, then asynchronous reset mid-test.
        addr_wr_i    = 1'b1;
        addr_wdata_i = 7'h50;
        tick();
        addr_wr_i = 1'b0;
        chk("addr_load", 32'(slave_addr_o), 32'h50);
        async_reset();
        chk("addr_after_rst", 32'(slave_addr_o), 32'h00);
        tick();

        // RX ordering.
        for (int i = 0; i < 3; i++) begin
            rx_wr_en_i = 1'b1;
            rx_wdata_i = rx_vals[i];
            tick();
        end
        rx_wr_en_i = 1'b0;
        chk("rx_count3", 32'(rx_count_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            rx_rd_en_i = 1'b1;
            tick();
            rx_rd_en_i = 1'b0;
            chk("rx_order_data",   32'(rx_rdata_o),  32'(rx_vals[i]));
            chk("rx_order_rvalid", 32'(rx_rvalid_o), 32'h1);
        end
        chk("rx_empty_after", 32'(rx_empty_o), 32'h1);
        tick();
        chk("rx_rvalid_pulse", 32'(rx_rvalid_o), 32'h0);

        // TX fill, overflow, drain, twice so the pointers wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) begin
                tx_wr_en_i = 1'b1;
                tx_wdata_i = 8'(i);
                tick();
            end
            chk("tx_full", 32'(tx_full_o), 32'h1);
            tx_wdata_i = 8'hEE;
            tick();
            tx_wr_en_i = 1'b0;
            chk("tx_ovf",       32'(tx_ovf_o),   32'h1);
            chk("tx_count_max", 32'(tx_count_o), 32'd256);
            tx_rd_en_i = 1'b1;
            for (int i = 0; i < 256; i++) begin
                tick();
                chk("tx_drain_data", 32'(tx_rdata_o), 32'(i));
            end
            tx_rd_en_i = 1'b0;
            chk("tx_empty_drained", 32'(tx_empty_o), 32'h1);
        end

        // Underflow, then push+pop on an empty FIFO.
        rx_rd_en_i = 1'b1;
        tick();
        rx_rd_en_i = 1'b0;
        chk("rx_udf",        32'(rx_udf_o),    32'h1);
        chk("rx_udf_rdata",  32'(rx_rdata_o),  32'hFF);
        chk("rx_udf_rvalid", 32'(rx_rvalid_o), 32'h0);
        rx_wr_en_i = 1'b1;
        rx_rd_en_i = 1'b1;
        rx_wdata_i = 8'h11;
        tick();
        idle();
        chk("rx_simul_count", 32'(rx_count_o), 32'd1);
        rx_rd_en_i = 1'b1;
        tick();
        rx_rd_en_i = 1'b0;
        chk("rx_simul_data", 32'(rx_rdata_o), 32'h11);

        // Flush with five entries and overflow pending, racing a write.
        rx_wr_en_i = 1'b1;
        for (int i = 0; i < 257; i++) begin
            rx_wdata_i = 8'($urandom);
            tick();
        end
        rx_wr_en_i = 1'b0;
        rx_rd_en_i = 1'b1;
        repeat (251) tick();
        rx_rd_en_i = 1'b0;
        chk("rx_pre_flush_count", 32'(rx_count_o), 32'd5);
        chk("rx_pre_flush_ovf",   32'(rx_ovf_o),   32'h1);
        rx_flush_i = 1'b1;
        rx_wr_en_i = 1'b1;
        rx_wdata_i = 8'h77;
        tick();
        idle();
        chk("rx_flush_count", 32'(rx_count_o), 32'd0);
        chk("rx_flush_ovf",   32'(rx_ovf_o),   32'h0);
        chk("rx_flush_empty", 32'(rx_empty_o), 32'h1);
        tick();
        chk("rx_flush_nowr", 32'(rx_count_o), 32'd0);

        // Random traffic; write bias alternates so both FIFOs swing between empty and full.
        for (int n = 0; n < 4000; n++) begin
            wr_pct       = ((n / 500) % 2 == 0) ? 90 : 10;
            addr_wr_i    = ($urandom_range(0, 15) == 0);
            addr_wdata_i = 7'($urandom);
            rx_wr_en_i   = ($urandom_range(0, 99) < wr_pct);
            rx_rd_en_i   = ($urandom_range(0, 99) >= wr_pct);
            rx_wdata_i   = 8'($urandom);
            rx_flush_i   = ($urandom_range(0, 199) == 0);
            tx_wr_en_i   = ($urandom_range(0, 99) < wr_pct);
            tx_rd_en_i   = ($urandom_range(0, 99) >= wr_pct);
            tx_wdata_i   = 8'($urandom);
            tx_flush_i   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                async_reset();
            end else begin
                tick();
            end
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
